microwave_timer: RTL and testbench

BCD countdown timer for the microwave controller: captures cook time from the keypad, counts it down once per second while the magnetron is energised, and produces `timer_done`, which feeds the magnetron controller's reset path. It consumes the controller's `mag_on` as its run enable, forming the timer/magnetron loop. Display drivers read the four BCD digits directly.

---
 rtl/microwave_timer.sv | 128 ++++++++++++
 tb/tb_microwave_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// BCD MM:SS countdown timer for the microwave controller.
// Optional MICROWAVE_TIMER_BEEP_EN adds a 3-tick beep when a countdown reaches 00:00.
module microwave_timer #(
  parameter int DIGITS_MAX = 9
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       clearn,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
`ifdef MICROWAVE_TIMER_BEEP_EN
  output logic       beep,
`endif
  output logic       finished
);

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_e;

  localparam logic [3:0] KMAX = 4'(DIGITS_MAX);

  state_e          state_q, state_d;
  // Digit 3 = min_tens ... digit 0 = sec_ones.
  logic [3:0][3:0] dig_q, dig_d, dec;
  logic            key_acc;

  assign key_acc = key_valid && (key_digit <= KMAX) && (state_q != RUN);

  // One-second BCD decrement; seconds borrow reloads 59 so 0:99 style entries still count down.
  always_comb begin
    dec = dig_q;
    if (dig_q[0] != 4'd0) begin
      dec[0] = dig_q[0] - 4'd1;
    end else if (dig_q[1] != 4'd0) begin
      dec[0] = 4'd9;
      dec[1] = dig_q[1] - 4'd1;
    end else if (dig_q[3:2] != '0) begin
      dec[0] = 4'd9;
      dec[1] = 4'd5;
      if (dig_q[2] != 4'd0) begin
        dec[2] = dig_q[2] - 4'd1;
      end else begin
        dec[2] = 4'd9;
        dec[3] = dig_q[3] - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    if (!clearn) begin
      state_d = IDLE;
      dig_d   = '0;
    end else if (state_q == RUN) begin
      if (tick_1hz) begin
        dig_d = dec;
        if (dec == '0)   state_d = DONE;
        else if (!mag_on) state_d = SET;
      end else if (!mag_on) begin
        state_d = SET;
      end
    end else if (key_acc) begin
      dig_d   = {dig_q[2:0], key_digit};
      state_d = ({dig_q[2:0], key_digit} == 16'd0) ? IDLE : SET;
    end else if (state_q == SET && mag_on) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = dig_q;
  assign timer_done = (dig_q == '0);
  assign finished   = (state_q == DONE);

`ifdef MICROWAVE_TIMER_BEEP_EN
  logic       beep_q, beep_d;
  logic [1:0] bcnt_q, bcnt_d;

  // The tick that lands on 00:00 starts the beep; it is not one of the three counted.
  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (!clearn || key_acc) begin
      beep_d = 1'b0;
      bcnt_d = 2'd0;
    end else if (state_d == DONE && state_q != DONE) begin
      beep_d = 1'b1;
      bcnt_d = 2'd0;
    end else if (beep_q && tick_1hz) begin
      if (bcnt_q == 2'd2) begin
        beep_d = 1'b0;
        bcnt_d = 2'd0;
      end else begin
        bcnt_d = bcnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beep_q <= 1'b0;
      bcnt_q <= 2'd0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign beep = beep_q;
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// Directed self-checking bench for microwave_timer (MM:SS BCD countdown).
module tb_microwave_timer;
  logic       clk = 1'b0;
  logic       rstn, tick_1hz, key_valid, clearn, mag_on;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, finished;
`ifdef MICROWAVE_TIMER_BEEP_EN
  logic       beep;
`endif
  int total = 0;
  int bad   = 0;

  microwave_timer #(.DIGITS_MAX(9)) dut (
    .clk(clk), .rstn(rstn), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .clearn(clearn), .mag_on(mag_on),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done),
`ifdef MICROWAVE_TIMER_BEEP_EN
    .beep(beep),
`endif
    .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [15:0] exp);
    chk(tag, {min_tens, min_ones, sec_tens, sec_ones}, {16'd0, exp});
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
    end
  endtask

  task automatic clr();
    mag_on = 1'b0; clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    clearn = 1'b1; mag_on = 1'b0;
    #2;
    chk_time("reset_time", 16'h0000);
    chk("reset_done", timer_done, 1);
    chk("reset_fin", finished, 0);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("reset_beep", beep, 0);
`endif
    rstn = 1'b1;
    cyc(1);

    // Key entry and invalid codes
    key(4'd1); key(4'd3); key(4'd0);
    chk_time("keys_130", 16'h0130);
    chk("keys_done", timer_done, 0);
    key(4'd12);
    chk_time("key12_ignored", 16'h0130);
    key(4'd15);
    chk_time("key15_ignored", 16'h0130);
    key(4'd2); key(4'd9);
    chk_time("shift_out_tens", 16'h3029);

    // 01:00 -> 00:59; tick coincident with mag_on rising is not counted
    clr();
    key(4'd1); key(4'd0); key(4'd0);
    mag_on = 1'b1;
    tick(1);
    chk_time("start_tick_ignored", 16'h0100);
    tick(1);
    chk_time("dec_0100", 16'h0059);

    // 0:99 -> 0:98
    clr();
    key(4'd9); key(4'd9);
    mag_on = 1'b1; cyc(1);
    tick(1);
    chk_time("dec_0099", 16'h0098);

    // 10:00 -> 09:59
    clr();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    mag_on = 1'b1; cyc(1);
    tick(1);
    chk_time("dec_1000", 16'h0959);

    // 00:02 to completion
    clr();
    key(4'd2);
    mag_on = 1'b1; cyc(1);
    tick(1);
    chk_time("dec_0002", 16'h0001);
    chk("fin_early", finished, 0);
    tick(1);
    chk_time("reach_zero", 16'h0000);
    chk("zero_done", timer_done, 1);
    chk("zero_fin", finished, 1);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_on", beep, 1);
`endif
    mag_on = 1'b0;
    tick(1);
    chk_time("post_zero_tick1", 16'h0000);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_t1", beep, 1);
`endif
    tick(1);
    chk("post_zero_fin", finished, 1);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_t2", beep, 1);
`endif
    tick(1);
    chk_time("post_zero_tick3", 16'h0000);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_t3_off", beep, 0);
`endif
    // Second completion, key pressed while beeping
    key(4'd1);
    mag_on = 1'b1; cyc(1);
    tick(1);
    chk("fin_again", finished, 1);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_again", beep, 1);
`endif
    mag_on = 1'b0;
    key(4'd3);
    chk_time("key_in_done", 16'h0003);
    chk("key_in_done_fin", finished, 0);
`ifdef MICROWAVE_TIMER_BEEP_EN
    chk("beep_key_off", beep, 0);
`endif

    // Pause and resume
    clr();
    key(4'd3); key(4'd0);
    mag_on = 1'b1; cyc(1);
    tick(5);
    chk_time("run5", 16'h0025);
    mag_on = 1'b0; cyc(1);
    tick(10);
    chk_time("paused", 16'h0025);
    mag_on = 1'b1; cyc(1);
    tick(1);
    chk_time("resumed", 16'h0024);
    mag_on = 1'b0;
    tick(1);
    chk_time("fall_with_tick", 16'h0023);
    tick(1);
    chk_time("after_fall", 16'h0023);

    // Key ignored in RUN; clear beats tick and key
    clr();
    key(4'd5); key(4'd0); key(4'd0);
    mag_on = 1'b1; cyc(1);
    key(4'd7);
    chk_time("key_in_run", 16'h0500);
    tick(1);
    chk_time("dec_0500", 16'h0459);
    clearn = 1'b0; tick_1hz = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    cyc(1);
    clearn = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0;
    chk_time("clear_wins", 16'h0000);
    chk("clear_done", timer_done, 1);
    chk("clear_fin", finished, 0);
    tick(1);
    chk_time("idle_magon", 16'h0000);
    key(4'd4);
    chk_time("key_after_clear", 16'h0004);

    // Asynchronous reset mid-RUN
    cyc(1);
    tick(1);
    chk_time("pre_rst", 16'h0003);
    #2 rstn = 1'b0;
    #1;
    chk_time("async_rst", 16'h0000);
    chk("async_rst_done", timer_done, 1);
    rstn = 1'b1;
    mag_on = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
